// File: rtl/axis_packet_fifo.sv
// AXI-stream FIFO with tlast framing: RAM plus a first-word-fall-through output register,
// optional store-and-forward release, occupancy/packet counters and an almost-full flag.
module axis_packet_fifo #(
    parameter int DATA_WIDTH        = 8,
    parameter int DEPTH             = 2048,
    parameter bit PACKET_MODE       = 1'b0,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   input_tdata,
    input  logic                    input_tvalid,
    output logic                    input_tready,
    input  logic                    input_tlast,
    output logic [DATA_WIDTH-1:0]   output_data,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic                    output_last,
    output logic [$clog2(DEPTH):0]  count,
    output logic [$clog2(DEPTH):0]  pkt_count,
    output logic                    almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, LOADED} rd_state_t;
    rd_state_t state, state_nxt;

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                ready_en;
    logic                in_pkt;
    logic                wr_en;
    logic                rd_en;
    logic                load;
    logic                releasable;
    logic [CW-1:0]       ram_cnt;
    logic [CW-1:0]       pkt_ram;
    logic [CW-1:0]       count_nxt;
    logic [CW-1:0]       pkt_nxt;

    // ready_en holds tready low through reset and releases it on the first edge afterwards
    assign input_tready = ready_en && (count < CW'(DEPTH));
    assign output_valid = (state == LOADED);
    assign wr_en        = input_tvalid && input_tready;
    assign rd_en        = output_valid && output_ready;
    assign ram_cnt      = count - CW'(output_valid);
    // complete packets whose tlast is still in the RAM, not in the output register
    assign pkt_ram      = pkt_count - CW'(output_valid && output_last);
    assign count_nxt    = count + CW'(wr_en) - CW'(rd_en);
    assign pkt_nxt      = pkt_count + CW'(wr_en && input_tlast) - CW'(rd_en && output_last);

    always_comb begin
        releasable = 1'b1;
        if (PACKET_MODE) begin
            // a full FIFO with no complete packet must cut through or it deadlocks
            releasable = in_pkt || (pkt_ram != '0) ||
                         ((count == CW'(DEPTH)) && (pkt_count == '0));
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if ((ram_cnt != '0) && releasable) begin
                    load      = 1'b1;
                    state_nxt = LOADED;
                end
            end
            LOADED: begin
                if (rd_en) begin
                    if ((ram_cnt != '0) && releasable) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pkt_count   <= '0;
            almost_full <= 1'b0;
            ready_en    <= 1'b0;
            in_pkt      <= 1'b0;
            output_data <= '0;
            output_last <= 1'b0;
        end else begin
            state       <= state_nxt;
            ready_en    <= 1'b1;
            count       <= count_nxt;
            pkt_count   <= pkt_nxt;
            almost_full <= (int'(count_nxt) >= ALMOST_FULL_LEVEL);
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr                     <= rd_ptr + 1'b1;
                {output_last, output_data} <= mem[rd_ptr];
                in_pkt                     <= !mem[rd_ptr][DATA_WIDTH];
            end
        end
    end

    // load only reads entries already present, so it never collides with this write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {input_tlast, input_tdata};
        end
    end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed bench for axis_packet_fifo: stream 16/2048-deep and packet-mode 16-deep instances
// share one stimulus bus; each scenario resets all and checks the instance it targets.
module tb_axis_packet_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        oready = 1'b0;

    logic        s16_tready, s16_valid, s16_last, s16_af;
    logic [7:0]  s16_data;
    logic [4:0]  s16_count, s16_pkt;
    logic        p16_tready, p16_valid, p16_last, p16_af;
    logic [7:0]  p16_data;
    logic [4:0]  p16_count, p16_pkt;
    logic        s2k_tready, s2k_valid, s2k_last, s2k_af;
    logic [15:0] s2k_data;
    logic [11:0] s2k_count, s2k_pkt;

    int total = 0;
    int bad = 0;
    logic [8:0] q[$];

    always #5 clk = ~clk;

    axis_packet_fifo #(.DATA_WIDTH(8), .DEPTH(16), .PACKET_MODE(1'b0)) u_s16 (
        .clk(clk), .reset(reset),
        .input_tdata(tdata[7:0]), .input_tvalid(tvalid), .input_tready(s16_tready),
        .input_tlast(tlast), .output_data(s16_data), .output_valid(s16_valid),
        .output_ready(oready), .output_last(s16_last), .count(s16_count),
        .pkt_count(s16_pkt), .almost_full(s16_af)
    );

    axis_packet_fifo #(.DATA_WIDTH(8), .DEPTH(16), .PACKET_MODE(1'b1)) u_p16 (
        .clk(clk), .reset(reset),
        .input_tdata(tdata[7:0]), .input_tvalid(tvalid), .input_tready(p16_tready),
        .input_tlast(tlast), .output_data(p16_data), .output_valid(p16_valid),
        .output_ready(oready), .output_last(p16_last), .count(p16_count),
        .pkt_count(p16_pkt), .almost_full(p16_af)
    );

    axis_packet_fifo #(.DATA_WIDTH(16), .DEPTH(2048), .PACKET_MODE(1'b0)) u_s2k (
        .clk(clk), .reset(reset),
        .input_tdata(tdata), .input_tvalid(tvalid), .input_tready(s2k_tready),
        .input_tlast(tlast), .output_data(s2k_data), .output_valid(s2k_valid),
        .output_ready(oready), .output_last(s2k_last), .count(s2k_count),
        .pkt_count(s2k_pkt), .almost_full(s2k_af)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        oready = 1'b0;
        tdata  = '0;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, nr, cyc, model;
        logic wr, rd, held_v;
        logic [8:0] held, exp9;

        // reset held for 3 cycles while the producer is pushing
        reset = 1'b1; tvalid = 1'b1; tdata = 16'h0005; tlast = 1'b1; oready = 1'b1;
        repeat (3) step();
        chk("rst_s16_tready", s16_tready, 0);
        chk("rst_s2k_tready", s2k_tready, 0);
        chk("rst_s16_count", s16_count, 0);
        chk("rst_s16_valid", s16_valid, 0);
        chk("rst_s16_data", s16_data, 0);
        chk("rst_s16_last", s16_last, 0);
        chk("rst_s16_af", s16_af, 0);
        chk("rst_p16_pkt", p16_pkt, 0);
        chk("rst_p16_af", p16_af, 0);
        tvalid = 1'b0; tlast = 1'b0; oready = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_tready_before_edge", s16_tready, 0);
        @(posedge clk); #1;
        chk("rst_tready_after_edge", s16_tready, 1);
        chk("rst_count_after_edge", s16_count, 0);

        // stream mode, 2048 deep: fill completely, then drain
        do_reset();
        for (int i = 1; i <= 2048; i++) begin
            tdata = 16'(i); tlast = (i % 16 == 0); tvalid = 1'b1;
            step();
        end
        tvalid = 1'b0; tlast = 1'b0;
        chk("s2k_full_tready", s2k_tready, 0);
        chk("s2k_full_count", s2k_count, 2048);
        chk("s2k_full_pkt", s2k_pkt, 128);
        chk("s2k_full_af", s2k_af, 1);
        oready = 1'b1; nr = 0; cyc = 0;
        while (nr < 2048 && cyc < 5000) begin
            if (s2k_valid) begin
                chk("s2k_data", s2k_data, nr + 1);
                chk("s2k_last", s2k_last, ((nr + 1) % 16 == 0));
                nr++;
            end
            step();
            cyc++;
        end
        oready = 1'b0;
        chk("s2k_drained", nr, 2048);
        chk("s2k_end_count", s2k_count, 0);
        chk("s2k_end_valid", s2k_valid, 0);
        chk("s2k_end_pkt", s2k_pkt, 0);

        // packet mode: nothing is released until tlast is stored
        do_reset();
        oready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tdata = 16'(8'h10 + i); tvalid = 1'b1; tlast = 1'b0;
            step();
            chk("pkt_hold_valid", p16_valid, 0);
        end
        tdata = 16'h0015; tlast = 1'b1;
        step();
        tvalid = 1'b0; tlast = 1'b0;
        chk("pkt_valid_edge1", p16_valid, 0);
        chk("pkt_count_one", p16_pkt, 1);
        step();
        for (int k = 0; k < 6; k++) begin
            chk("pkt_out_valid", p16_valid, 1);
            chk("pkt_out_data", p16_data, 8'h10 + k);
            chk("pkt_out_last", p16_last, (k == 5));
            step();
        end
        oready = 1'b0;
        chk("pkt_end_valid", p16_valid, 0);
        chk("pkt_end_count", p16_count, 0);
        chk("pkt_end_pkt", p16_pkt, 0);

        // stream mode, 16 deep: full FIFO with simultaneous write attempt and read
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            tdata = 16'(i); tvalid = 1'b1; tlast = 1'b0;
            step();
        end
        tvalid = 1'b0;
        chk("full_tready", s16_tready, 0);
        chk("full_count", s16_count, 16);
        chk("full_head", s16_data, 1);
        tvalid = 1'b1; tdata = 16'h00AA; oready = 1'b1;
        step();
        tvalid = 1'b0; oready = 1'b0;
        chk("full_rw_count", s16_count, 15);
        chk("full_rw_tready", s16_tready, 1);
        chk("full_rw_head", s16_data, 2);
        // reset mid-operation clears state without waiting for a clock edge
        reset = 1'b1;
        #1;
        chk("async_rst_count", s16_count, 0);
        chk("async_rst_valid", s16_valid, 0);
        chk("async_rst_tready", s16_tready, 0);
        #1;
        reset = 1'b0;
        step();

        // packet mode, 16 deep: 40-word packet must cut through instead of deadlocking
        do_reset();
        oready = 1'b1; nw = 0; nr = 0; cyc = 0;
        while ((nw < 40 || nr < 40) && cyc < 1000) begin
            tvalid = (nw < 40);
            tdata  = 16'(nw + 1);
            tlast  = (nw == 39);
            wr = tvalid && p16_tready;
            rd = p16_valid && oready;
            if (rd) begin
                chk("ovs_data", p16_data, nr + 1);
                chk("ovs_last", p16_last, (nr == 39));
                nr++;
            end
            if (wr) nw++;
            step();
            cyc++;
        end
        tvalid = 1'b0; tlast = 1'b0; oready = 1'b0;
        chk("ovs_reads", nr, 40);
        chk("ovs_end_count", p16_count, 0);
        chk("ovs_end_pkt", p16_pkt, 0);

        // stream mode, 16 deep: random valid/ready, pointer wrap, stall stability
        do_reset();
        q.delete();
        nw = 0; nr = 0; cyc = 0; model = 0;
        while ((nw < 100 || nr < 100) && cyc < 3000) begin
            tvalid = (nw < 100) && ($urandom_range(0, 1) == 1);
            oready = ($urandom_range(0, 1) == 1);
            tdata  = 16'($urandom_range(0, 255));
            tlast  = (nw % 7 == 6);
            wr = tvalid && s16_tready;
            rd = s16_valid && oready;
            if (rd) begin
                if (q.size() == 0) begin
                    chk("wrap_underflow", 1, 0);
                end else begin
                    exp9 = q.pop_front();
                    chk("wrap_word", {s16_last, s16_data}, exp9);
                end
                nr++;
            end
            held_v = s16_valid && !oready;
            held   = {s16_last, s16_data};
            if (wr) begin
                q.push_back({tlast, tdata[7:0]});
                nw++;
            end
            model = model + int'(wr) - int'(rd);
            step();
            cyc++;
            chk("wrap_count", s16_count, model);
            if (held_v) begin
                chk("wrap_stall", {s16_valid, s16_last, s16_data}, {1'b1, held});
            end
        end
        tvalid = 1'b0; oready = 1'b0;
        chk("wrap_reads", nr, 100);
        chk("wrap_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
